// File: rtl/fir_filter_flex_mac.sv
// Time-multiplexed symbol FIR: NUM_MAC lanes, double-buffered coefficient bank.
// Define FIR_OUT_SAT_EN to saturate the scaled output instead of wrapping.
module fir_filter_flex_mac #(
  parameter int TAPS      = 40,
  parameter int NUM_MAC   = 4,
  parameter int IN_W      = 3,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0,
  parameter int ADDR_W    = 6
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iEnSample600k,
  input  logic              iCoeffUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [COEF_W-1:0] iWrDtRam,
  output logic [COEF_W-1:0] oRdDtRam,
  input  logic [IN_W-1:0]   iFirIn,
  output logic [OUT_W-1:0]  oFirOut,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOverrun
);

  localparam int TPL    = TAPS / NUM_MAC;
  localparam int KW     = (TPL > 1) ? $clog2(TPL) : 1;
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'((64'd1 << OUT_SHIFT) >> 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_SUM,
    S_OUT
  } state_t;

  state_t                   state_q;
  logic [KW-1:0]            k_q;
  logic signed [IN_W-1:0]   x_q   [TAPS];
  logic signed [COEF_W-1:0] shd_q [TAPS];
  logic signed [COEF_W-1:0] act_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q [NUM_MAC];
  logic signed [PROD_W-1:0] prod_d [NUM_MAC];
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  sum_d;
  logic [OUT_W-1:0]         out_q;
  logic [OUT_W-1:0]         out_d;
  logic [COEF_W-1:0]        rd_q;
  logic                     flag_q;
  logic                     pend_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     ovr_q;

  logic addr_ok;
  logic wr_en;
  logic rd_en;
  logic fall;
  logic idle;
  logic swap;

  assign addr_ok = int'(iAddrRam) < TAPS;
  assign wr_en   = !iCsnRam && !iWrnRam && iCoeffUpdateFlag && addr_ok;
  assign rd_en   = !iCsnRam && iWrnRam;
  assign fall    = flag_q && !iCoeffUpdateFlag;
  assign idle    = state_q == S_IDLE;
  assign swap    = idle && (pend_q || fall);

  // Lane l owns taps l*TPL .. l*TPL+TPL-1, walked by k_q.
  always_comb begin
    for (int l = 0; l < NUM_MAC; l++) begin
      prod_d[l] = PROD_W'(x_q[l*TPL + int'(k_q)])
                * PROD_W'(act_q[l*TPL + int'(k_q)]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int l = 0; l < NUM_MAC; l++) begin
      sum_d = sum_d + acc_q[l];
    end
    sum_d = (sum_d + RND) >>> OUT_SHIFT;
  end

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [ACC_W-1:0] OMAX =
    ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OMIN = -OMAX - 1;

  always_comb begin
    out_d = sum_q[OUT_W-1:0];
    if (sum_q > OMAX) begin
      out_d = OMAX[OUT_W-1:0];
    end else if (sum_q < OMIN) begin
      out_d = OMIN[OUT_W-1:0];
    end
  end
`else
  assign out_d = sum_q[OUT_W-1:0];
`endif

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      rd_q    <= '0;
      flag_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int t = 0; t < TAPS; t++) begin
        x_q[t]   <= '0;
        shd_q[t] <= '0;
        act_q[t] <= '0;
      end
      for (int l = 0; l < NUM_MAC; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      flag_q  <= iCoeffUpdateFlag;
      valid_q <= 1'b0;

      if (wr_en) begin
        shd_q[iAddrRam] <= iWrDtRam;
      end
      if (rd_en) begin
        rd_q <= addr_ok ? shd_q[iAddrRam] : '0;
      end

      // Copy lands before the first MAC cycle of a coincident start.
      if (swap) begin
        act_q  <= shd_q;
        pend_q <= 1'b0;
      end else if (fall) begin
        pend_q <= 1'b1;
      end

      if (iEnSample600k && !idle) begin
        ovr_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (iEnSample600k) begin
            x_q[0] <= iFirIn;
            for (int t = 1; t < TAPS; t++) begin
              x_q[t] <= x_q[t-1];
            end
            for (int l = 0; l < NUM_MAC; l++) begin
              acc_q[l] <= '0;
            end
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          for (int l = 0; l < NUM_MAC; l++) begin
            acc_q[l] <= acc_q[l] + ACC_W'(prod_d[l]);
          end
          k_q <= k_q + 1'b1;
          if (k_q == KW'(TPL - 1)) begin
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          sum_q   <= sum_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          out_q   <= out_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oRdDtRam = rd_q;
  assign oFirOut  = out_q;
  assign oValid   = valid_q;
  assign oBusy    = busy_q;
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_fir_filter_flex_mac.sv
// Bench for fir_filter_flex_mac: vector table, directed corners, random vs model.
// Output expectations follow FIR_OUT_SAT_EN when it is defined.
module tb_fir_filter_flex_mac;

  localparam int TAPS      = 40;
  localparam int NUM_MAC   = 4;
  localparam int TPL       = TAPS / NUM_MAC;
  localparam int LAT       = TPL + 2;
  localparam int OUT_SHIFT = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        iEn;
  logic        iFlag;
  logic        iCsn;
  logic        iWrn;
  logic [5:0]  iAddr;
  logic [15:0] iWrDt;
  logic [15:0] oRdDt;
  logic [2:0]  iFirIn;
  logic [15:0] oFirOut;
  logic        oValid;
  logic        oBusy;
  logic        oOverrun;

  fir_filter_flex_mac #(
    .TAPS(TAPS), .NUM_MAC(NUM_MAC), .IN_W(3), .COEF_W(16),
    .OUT_W(16), .OUT_SHIFT(OUT_SHIFT), .ADDR_W(6)
  ) dut (
    .iClk12M(clk),
    .iRst(rst),
    .iEnSample600k(iEn),
    .iCoeffUpdateFlag(iFlag),
    .iCsnRam(iCsn),
    .iWrnRam(iWrn),
    .iAddrRam(iAddr),
    .iWrDtRam(iWrDt),
    .oRdDtRam(oRdDt),
    .iFirIn(iFirIn),
    .oFirOut(oFirOut),
    .oValid(oValid),
    .oBusy(oBusy),
    .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int m_shd [TAPS];
  int m_act [TAPS];
  int hist  [TAPS];

  typedef struct {
    bit          wr;
    bit          flag;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } acc_vec_t;

  acc_vec_t tbl [8];
  logic [15:0] y;
  logic [2:0]  xs [4];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_shd[k] = 0;
      m_act[k] = 0;
      hist[k]  = 0;
    end
  endfunction

  function automatic void push(input logic [2:0] x);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(x));
  endfunction

  function automatic logic [15:0] model_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) begin
      s += longint'(m_act[k]) * longint'(hist[k]);
    end
    s = (s + ((longint'(1) << OUT_SHIFT) >>> 1)) >>> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    iEn = 1'b0;
    iFlag = 1'b0;
    iCsn = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_flag(input logic v);
    if (iFlag && !v) m_act = m_shd;
    iFlag = v;
    tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    iCsn = 1'b0; iWrn = 1'b0; iAddr = a; iWrDt = d;
    tick();
    iCsn = 1'b1;
    if (iFlag && a < TAPS) m_shd[a] = int'($signed(d));
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] exp,
                    input string nm);
    iCsn = 1'b0; iWrn = 1'b1; iAddr = a;
    tick();
    iCsn = 1'b1;
    chk(nm, oRdDt, exp);
  endtask

  // fall_at: -1 none, 0 drop flag with the strobe, >0 drop mid-computation.
  task automatic strobe(input logic [2:0] x, input int fall_at,
                        output logic [15:0] yo);
    logic [15:0] exp;
    int lat;
    if (fall_at == 0 && iFlag) begin
      m_act = m_shd;
      iFlag = 1'b0;
    end
    iFirIn = x;
    iEn = 1'b1;
    push(x);
    exp = model_y();
    tick();
    iEn = 1'b0;
    lat = 0;
    while (oValid !== 1'b1 && lat < 3 * LAT) begin
      tick();
      lat++;
      if (lat == 1) chk("busy_rise", oBusy, 1);
      if (lat == fall_at && iFlag) begin
        m_act = m_shd;
        iFlag = 1'b0;
      end
    end
    chk("latency", lat, LAT);
    chk("busy_fall", oBusy, 0);
    chk("y_model", oFirOut, exp);
    yo = oFirOut;
    tick();
    chk("valid_pulse", oValid, 0);
  endtask

  initial begin
    int lat;
    int vseen;
    logic [5:0] a;
    logic [15:0] d;

    tbl[0] = '{1'b1, 1'b0, 6'd3,  16'h1234, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 6'd3,  16'h1234, 16'h1234};
    tbl[2] = '{1'b1, 1'b1, 6'd45, 16'h5555, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 6'd5,  16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 6'd39, 16'h8001, 16'h8001};
    tbl[5] = '{1'b1, 1'b1, 6'd40, 16'h7777, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 6'd39, 16'h0000, 16'h8001};
    tbl[7] = '{1'b0, 1'b0, 6'd3,  16'h0000, 16'h1234};
    xs[0] = 3'b001; xs[1] = 3'b011; xs[2] = 3'b111; xs[3] = 3'b101;

    iWrn = 1'b1; iAddr = '0; iWrDt = '0; iFirIn = '0;
    do_reset(3);
    chk("rst_out", oFirOut, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_ovr", oOverrun, 0);
    chk("rst_rd", oRdDt, 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].flag != iFlag) set_flag(tbl[i].flag);
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      rd(tbl[i].addr, tbl[i].exp, "access_tbl");
    end
    tick();
    chk("rd_hold", oRdDt, 16'h1234);

    do_reset(1);
    iFlag = 1'b1;
    for (int k = 0; k < TAPS; k++) wr(6'(k), 16'(k + 1));
    set_flag(1'b0);
    tick();
    strobe(3'b001, -1, y);
    chk("impulse", y, 1);
    for (int n = 1; n <= TAPS; n++) begin
      strobe(3'b000, -1, y);
      chk("impulse", y, (n < TAPS) ? n + 1 : 0);
    end
    chk("no_ovr", oOverrun, 0);

    do_reset(1);
    iFlag = 1'b1;
    wr(6'd0, 16'd21845);
    set_flag(1'b0);
    strobe(3'b101, -1, y);
`ifdef FIR_OUT_SAT_EN
    chk("scale", y, 16'h8000);
`else
    chk("scale", y, 16'h0001);
`endif

    do_reset(1);
    iFlag = 1'b1;
    wr(6'd0, 16'd100);
    set_flag(1'b0);
    set_flag(1'b1);
    wr(6'd0, 16'd7);
    strobe(3'b001, -1, y);
    chk("swap_hold", y, 100);
    strobe(3'b001, -1, y);
    chk("swap_hold", y, 100);
    strobe(3'b001, 0, y);
    chk("swap_same", y, 7);
    set_flag(1'b1);
    wr(6'd0, 16'd9);
    strobe(3'b001, 4, y);
    chk("swap_midbusy", y, 7);
    strobe(3'b001, -1, y);
    chk("swap_after", y, 9);

    do_reset(1);
    iFlag = 1'b1;
    wr(6'd0, 16'd1);
    wr(6'd1, 16'd2);
    set_flag(1'b0);
    iFirIn = 3'b001;
    iEn = 1'b1;
    push(3'b001);
    tick();
    iEn = 1'b0;
    repeat (4) tick();
    iFirIn = 3'b011;
    iEn = 1'b1;
    tick();
    iEn = 1'b0;
    chk("ovr_set", oOverrun, 1);
    lat = 5;
    while (oValid !== 1'b1 && lat < 3 * LAT) begin
      tick();
      lat++;
    end
    chk("ovr_latency", lat, LAT);
    chk("ovr_y", oFirOut, 1);
    tick();
    strobe(3'b000, -1, y);
    chk("ovr_shift_once", y, 2);
    chk("ovr_sticky", oOverrun, 1);

    do_reset(1);
    iFlag = 1'b1;
    wr(6'd0, 16'd5);
    set_flag(1'b0);
    rd(6'd0, 16'd5, "pre_rst_rd");
    strobe(3'b001, -1, y);
    iEn = 1'b1;
    tick();
    iEn = 1'b0;
    tick();
    iEn = 1'b1;
    tick();
    iEn = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out", oFirOut, 0);
    chk("midrst_valid", oValid, 0);
    chk("midrst_busy", oBusy, 0);
    chk("midrst_ovr", oOverrun, 0);
    chk("midrst_rd", oRdDt, 0);
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    vseen = 0;
    repeat (2 * LAT) begin
      tick();
      if (oValid === 1'b1) vseen++;
    end
    chk("midrst_no_valid", vseen, 0);
    rd(6'd0, 16'd0, "midrst_bank");
    strobe(3'b001, -1, y);
    chk("midrst_active", y, 0);

    do_reset(1);
    iFlag = 1'b1;
    for (int k = 0; k < TAPS; k++) wr(6'(k), 16'($urandom));
    set_flag(1'b0);
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 8)) tick();
      if (n == 15) begin
        set_flag(1'b1);
        for (int j = 0; j < 4; j++) begin
          wr(6'($urandom_range(0, TAPS - 1)), 16'($urandom));
        end
        strobe(xs[$urandom_range(0, 3)], 4, y);
      end else begin
        strobe(xs[$urandom_range(0, 3)], -1, y);
      end
      a = 6'($urandom_range(0, 47));
      d = (a < TAPS) ? 16'(m_shd[a]) : 16'h0000;
      rd(a, d, "rand_rd");
    end
    chk("rand_no_ovr", oOverrun, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
